// File: rtl/prefetch_pipe_pkg.sv
// Shared widths, reset address and FIFO depth for the pipelined instruction prefetch.
// No logic or storage of its own.
// No handshake.
package prefetch_pipe_pkg;
  localparam int          AW_DEF            = 30;
  localparam int          DW_DEF            = 32;
  localparam int          LGDEPTH_DEF       = 2;
  localparam logic [31:0] RESET_ADDRESS_DEF = 32'h0;

  function automatic int depth_of(input int lgdepth);
    return 1 << lgdepth;
  endfunction
endpackage

// File: rtl/prefetch_pipe_fifo.sv
// In-order instruction buffer: each entry holds an illegal flag and a data word.
// One cycle from push to a visible head entry; flush empties it on the next edge.
// No internal backpressure: the caller keeps pushes within depth and pops only when non-empty.
module pf_fifo #(
  parameter int WIDTH   = 33,
  parameter int LGDEPTH = 2
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               push_vld,
  input  logic [WIDTH-1:0]   push_dat,
  input  logic               pop_vld,
  input  logic               flush,
  output logic [WIDTH-1:0]   head_dat,
  output logic [LGDEPTH:0]   count,
  output logic               empty
);
  localparam int DEPTH = 1 << LGDEPTH;

  logic [WIDTH-1:0]   mem [DEPTH];
  logic [LGDEPTH-1:0] wr_ptr, rd_ptr;
  logic               do_pop;

  assign empty    = (count == '0);
  assign do_pop   = pop_vld & ~empty;
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_vld) wr_ptr <= wr_ptr + LGDEPTH'(1);
      if (do_pop)   rd_ptr <= rd_ptr + LGDEPTH'(1);
      count <= count + (LGDEPTH+1)'(push_vld) - (LGDEPTH+1)'(do_pop);
    end
  end

  // Storage is deliberately left out of reset; only the pointers define validity.
  always_ff @(posedge i_clk) begin
    if (push_vld && !flush) mem[wr_ptr] <= push_dat;
  end
endmodule

// File: rtl/prefetch_pipe.sv
// Pipelined Wishbone instruction prefetch with up to DEPTH reads in flight and an in-order buffer.
// Branch to first strobe is two edges; with single-cycle acks the first word is valid four cycles after the branch.
// Stops strobing once buffered plus outstanding words reach DEPTH; CPU stalls simply hold the buffer head.
module prefetch_pipe
  import prefetch_pipe_pkg::*;
#(
  parameter int                       ADDRESS_WIDTH = AW_DEF,
  parameter int                       DATA_WIDTH    = DW_DEF,
  parameter int                       LGDEPTH       = LGDEPTH_DEF,
  parameter logic [ADDRESS_WIDTH+1:0] RESET_ADDRESS = (ADDRESS_WIDTH+2)'(RESET_ADDRESS_DEF)
) (
  input  logic                       i_clk,
  input  logic                       i_reset_n,
  input  logic                       i_new_pc,
  input  logic                       i_clear_cache,
  input  logic                       i_stalled_n,
  input  logic [ADDRESS_WIDTH+1:0]   i_pc,
  output logic [DATA_WIDTH-1:0]      o_insn,
  output logic [ADDRESS_WIDTH+1:0]   o_pc,
  output logic                       o_valid,
  output logic                       o_illegal,
  output logic                       o_wb_cyc,
  output logic                       o_wb_stb,
  output logic                       o_wb_we,
  output logic [ADDRESS_WIDTH-1:0]   o_wb_addr,
  output logic [DATA_WIDTH-1:0]      o_wb_data,
  input  logic                       i_wb_stall,
  input  logic                       i_wb_ack,
  input  logic                       i_wb_err,
  input  logic [DATA_WIDTH-1:0]      i_wb_data
);
  localparam int                       DEPTH   = depth_of(LGDEPTH);
  localparam int                       CW      = LGDEPTH + 1;
  localparam logic [ADDRESS_WIDTH+1:0] LSB_MSK = (ADDRESS_WIDTH+2)'(3);

  logic                     cyc, stb, halted;
  logic [CW-1:0]            pending, count;
  logic [ADDRESS_WIDTH-1:0] wb_addr;
  logic [ADDRESS_WIDTH+1:0] pc;
  logic                     fifo_empty;
  logic [DATA_WIDTH:0]      head_dat, push_dat;

  logic          flush, accept, ack_v, err_v, push, pop, stb_nx;
  logic [CW-1:0] pending_nx, count_nx;
  logic [CW:0]   load_nx;

  always_comb begin
    flush      = i_new_pc | i_clear_cache;
    accept     = stb & ~i_wb_stall;
    err_v      = cyc & i_wb_err;
    ack_v      = cyc & i_wb_ack & ~i_wb_err;
    push       = ~flush & (ack_v | err_v);
    pop        = ~flush & ~fifo_empty & i_stalled_n;
    push_dat   = err_v ? {1'b1, {DATA_WIDTH{1'b0}}} : {1'b0, i_wb_data};
    count_nx   = count + CW'(push) - CW'(pop);
    pending_nx = pending + CW'(accept) - CW'(ack_v);
    // Everything either buffered or still on the bus must fit in the FIFO.
    load_nx    = {1'b0, count_nx} + {1'b0, pending_nx};
    stb_nx     = ~halted & (load_nx < (CW+1)'(DEPTH));
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cyc     <= 1'b0;
      stb     <= 1'b0;
      halted  <= 1'b0;
      pending <= '0;
      wb_addr <= RESET_ADDRESS[ADDRESS_WIDTH+1:2];
      pc      <= RESET_ADDRESS & ~LSB_MSK;
    end else if (i_new_pc) begin
      cyc     <= 1'b0;
      stb     <= 1'b0;
      halted  <= 1'b0;
      pending <= '0;
      wb_addr <= i_pc[ADDRESS_WIDTH+1:2];
      pc      <= i_pc & ~LSB_MSK;
    end else if (i_clear_cache || err_v) begin
      // Abort the bus cycle; outstanding replies are abandoned with it.
      cyc     <= 1'b0;
      stb     <= 1'b0;
      halted  <= 1'b1;
      pending <= '0;
      if (accept) wb_addr <= wb_addr + ADDRESS_WIDTH'(1);
      if (pop)    pc      <= pc + (ADDRESS_WIDTH+2)'(4);
    end else begin
      stb     <= stb_nx;
      cyc     <= stb_nx | (pending_nx != '0);
      pending <= pending_nx;
      if (accept) wb_addr <= wb_addr + ADDRESS_WIDTH'(1);
      if (pop)    pc      <= pc + (ADDRESS_WIDTH+2)'(4);
    end
  end

  pf_fifo #(
    .WIDTH   (DATA_WIDTH + 1),
    .LGDEPTH (LGDEPTH)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .push_vld  (push),
    .push_dat  (push_dat),
    .pop_vld   (pop),
    .flush     (flush),
    .head_dat  (head_dat),
    .count     (count),
    .empty     (fifo_empty)
  );

  ack_overflow: assert property (@(posedge i_clk) disable iff (!i_reset_n)
    !(ack_v && !flush && count == CW'(DEPTH)));

  assign o_wb_cyc  = cyc;
  assign o_wb_stb  = stb;
  assign o_wb_we   = 1'b0;
  assign o_wb_addr = wb_addr;
  assign o_wb_data = '0;
  assign o_pc      = pc;
  assign o_valid   = ~fifo_empty;
  assign o_illegal = ~fifo_empty & head_dat[DATA_WIDTH];
  assign o_insn    = head_dat[DATA_WIDTH-1:0];
endmodule

// File: tb/tb_prefetch_pipe.sv
// Directed bench for prefetch_pipe: Wishbone slave model plus a fetch-stream reference model.
module tb_prefetch_pipe;
  localparam int AW = 30, DW = 32, LGD = 2, DEPTH = 4;

  logic          i_clk = 1'b0, i_reset_n = 1'b0;
  logic          i_new_pc = 1'b0, i_clear_cache = 1'b0, i_stalled_n = 1'b1;
  logic [AW+1:0] i_pc = '0;
  logic [DW-1:0] o_insn, o_wb_data;
  logic [AW+1:0] o_pc;
  logic          o_valid, o_illegal, o_wb_cyc, o_wb_stb, o_wb_we;
  logic [AW-1:0] o_wb_addr;
  logic          i_wb_stall = 1'b0, i_wb_ack = 1'b0, i_wb_err = 1'b0;
  logic [DW-1:0] i_wb_data = '0;

  prefetch_pipe #(
    .ADDRESS_WIDTH (AW), .DATA_WIDTH (DW), .LGDEPTH (LGD), .RESET_ADDRESS ('0)
  ) dut (
    .i_clk (i_clk), .i_reset_n (i_reset_n), .i_new_pc (i_new_pc),
    .i_clear_cache (i_clear_cache), .i_stalled_n (i_stalled_n), .i_pc (i_pc),
    .o_insn (o_insn), .o_pc (o_pc), .o_valid (o_valid), .o_illegal (o_illegal),
    .o_wb_cyc (o_wb_cyc), .o_wb_stb (o_wb_stb), .o_wb_we (o_wb_we),
    .o_wb_addr (o_wb_addr), .o_wb_data (o_wb_data), .i_wb_stall (i_wb_stall),
    .i_wb_ack (i_wb_ack), .i_wb_err (i_wb_err), .i_wb_data (i_wb_data)
  );

  initial forever #5 i_clk = ~i_clk;

  int n_tests = 0, n_fail = 0;

  // Slave state
  logic [AW-1:0] q[$];
  int            n_req = 0, err_cnt = 0;
  bit            hold = 0, stall_rand = 0, jtog = 0;

  // Reference model state
  logic [AW+1:0] exp_pc = '0, err_pc = '0;
  logic [AW-1:0] exp_req = '0, resp_word = '0;
  bit            err_vld = 0, m_halt = 0, flush_prev = 0;
  int            np_age = 0;

  function automatic logic [DW-1:0] mem(input logic [AW-1:0] w);
    logic [DW-1:0] x;
    x = DW'(w);
    return x * 32'h01010101 + 32'hA5000000;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  task automatic model_step();
    bit exp_ill;
    exp_ill = 0;
    if (!i_reset_n) begin
      exp_pc = '0; exp_req = '0; resp_word = '0;
      err_vld = 0; m_halt = 0; flush_prev = 0; np_age = 0;
      return;
    end
    check("wb_we", o_wb_we, 0);
    check("wb_data", o_wb_data, 0);
    if (flush_prev) check("flush_valid", o_valid, 0);
    if (np_age == 1) check("restart_cyc_low", o_wb_cyc, 0);
    if (np_age == 2) check("restart_stb", o_wb_stb, 1);
    if (m_halt) check("halt_valid", o_valid, 0);
    if (o_wb_stb) check("wb_addr", o_wb_addr, exp_req);
    if (o_valid && !m_halt) begin
      exp_ill = err_vld && (exp_pc == err_pc);
      check("pc", o_pc, exp_pc);
      check("illegal", o_illegal, exp_ill);
      check("insn", o_insn, exp_ill ? 32'h0 : mem(exp_pc[AW+1:2]));
    end
    flush_prev = i_new_pc || i_clear_cache;
    np_age = i_new_pc ? 1 : (np_age == 1 ? 2 : 0);
    if (i_new_pc) begin
      exp_pc = {i_pc[AW+1:2], 2'b00};
      exp_req = i_pc[AW+1:2];
      resp_word = i_pc[AW+1:2];
      m_halt = 0; err_vld = 0;
    end else begin
      if (o_wb_stb && !i_wb_stall) exp_req = exp_req + 1'b1;
      if (i_clear_cache) m_halt = 1;
      else begin
        if (o_wb_cyc && i_wb_err && !err_vld) begin
          err_vld = 1; err_pc = {resp_word, 2'b00};
        end else if (o_wb_cyc && i_wb_ack) resp_word = resp_word + 1'b1;
        if (o_valid && i_stalled_n && !m_halt) begin
          if (exp_ill) m_halt = 1;
          exp_pc = exp_pc + 4;
        end
      end
    end
  endtask

  task automatic slave_step();
    logic [AW-1:0] w;
    i_wb_ack = 0; i_wb_err = 0; i_wb_data = '0;
    i_wb_stall = stall_rand ? 1'($urandom_range(0, 1)) : 1'b0;
    if (!i_reset_n || !o_wb_cyc) begin
      q.delete();
      // Stray responses outside a bus cycle must be ignored.
      if (jtog) i_wb_ack = 1; else i_wb_err = 1;
      i_wb_data = 32'hDEADBEEF;
      jtog = !jtog;
    end else begin
      if (!hold && q.size() > 0) begin
        w = q.pop_front();
        if (err_cnt == 1) i_wb_err = 1;
        else begin i_wb_ack = 1; i_wb_data = mem(w); end
        if (err_cnt > 0) err_cnt--;
      end
      if (o_wb_stb && !i_wb_stall) begin q.push_back(o_wb_addr); n_req++; end
      check("pending_max", q.size() <= DEPTH, 1);
    end
  endtask

  task automatic tick();
    @(negedge i_clk); model_step();
    @(posedge i_clk); #1; slave_step();
  endtask

  task automatic branch(input logic [AW+1:0] pc);
    i_new_pc = 1; i_pc = pc;
    tick();
    i_new_pc = 0; i_clear_cache = 0;
  endtask

  task automatic wait_valid(input string name, output int n);
    n = 0;
    while (!o_valid && n < 30) begin tick(); n++; end
    check({name, "_valid"}, o_valid, 1);
  endtask

  initial begin
    int n, n0;
    // Reset state
    repeat (2) @(posedge i_clk);
    #1;
    check("rst_cyc", o_wb_cyc, 0);   check("rst_stb", o_wb_stb, 0);
    check("rst_valid", o_valid, 0);  check("rst_illegal", o_illegal, 0);
    check("rst_pc", o_pc, 0);        check("rst_addr", o_wb_addr, 0);
    i_reset_n = 1;
    tick();
    check("first_stb", o_wb_stb, 1); check("first_cyc", o_wb_cyc, 1);
    check("first_addr", o_wb_addr, 0);

    // Streaming, single-cycle acks, CPU always ready
    wait_valid("stream", n);
    check("stream_pc0", o_pc, 32'h0);
    check("stream_insn0", o_insn, 32'hA5000000);
    for (int i = 0; i < 20; i++) begin tick(); check("stream_cont", o_valid, 1); end
    check("stream_pc20", o_pc, 32'h50);
    check("stream_insn20", o_insn, 32'hB9141414);

    // CPU stalled: exactly DEPTH requests, then idle with a full buffer
    i_stalled_n = 0;
    branch(32'h200);
    n0 = n_req;
    repeat (20) tick();
    check("stall_reqs", n_req - n0, 4);
    check("stall_stb", o_wb_stb, 0);  check("stall_cyc", o_wb_cyc, 0);
    check("stall_valid", o_valid, 1); check("stall_pc", o_pc, 32'h200);
    check("stall_insn", o_insn, 32'h25808080);
    i_stalled_n = 1;
    n0 = n_req;
    for (int i = 0; i < 6; i++) begin tick(); check("unstall_cont", o_valid, 1); end
    check("unstall_resume", n_req > n0, 1);
    check("unstall_pc", o_pc, 32'h218);

    // Branch with three requests outstanding
    hold = 1;
    n = 0;
    while (q.size() != 3 && n < 10) begin tick(); n++; end
    check("hold_outstanding", q.size(), 3);
    hold = 0;
    branch(32'h100);
    check("branch_cyc_low", o_wb_cyc, 0);
    wait_valid("branch", n);
    check("branch_latency", n, 3);
    check("branch_pc", o_pc, 32'h100);
    check("branch_insn", o_insn, 32'hE5404040);

    // Bus error on the third response
    branch(32'h0);
    err_cnt = 3;
    n = 0;
    while (!(o_valid && o_illegal) && n < 20) begin tick(); n++; end
    check("err_illegal", o_illegal, 1);
    check("err_pc", o_pc, 32'h8);
    check("err_insn", o_insn, 0);
    n0 = n_req;
    repeat (11) tick();
    check("err_halt_reqs", n_req - n0, 0);
    check("err_halt_valid", o_valid, 0);
    check("err_halt_cyc", o_wb_cyc, 0);
    branch(32'h20);
    check("err_clear_illegal", o_illegal, 0);
    wait_valid("err_restart", n);
    check("err_restart_pc", o_pc, 32'h20);

    // Cache clear mid-burst, then clear and branch together
    branch(32'h300);
    repeat (5) tick();
    i_clear_cache = 1;
    tick();
    i_clear_cache = 0;
    check("clr_valid", o_valid, 0);
    check("clr_cyc", o_wb_cyc, 0);
    n0 = n_req;
    repeat (10) tick();
    check("clr_idle_reqs", n_req - n0, 0);
    check("clr_idle_valid", o_valid, 0);
    i_clear_cache = 1;
    branch(32'h340);
    wait_valid("clr_restart", n);
    check("clr_restart_pc", o_pc, 32'h340);

    // Random bus stalls, then asynchronous reset mid-burst
    stall_rand = 1;
    repeat (40) tick();
    #2 i_reset_n = 0;
    #1;
    check("arst_cyc", o_wb_cyc, 0);   check("arst_stb", o_wb_stb, 0);
    check("arst_valid", o_valid, 0);  check("arst_illegal", o_illegal, 0);
    check("arst_pc", o_pc, 0);        check("arst_addr", o_wb_addr, 0);
    repeat (2) tick();
    i_reset_n = 1;
    stall_rand = 0;
    wait_valid("arst_restart", n);
    check("arst_restart_pc", o_pc, 32'h0);
    check("arst_restart_insn", o_insn, 32'hA5000000);
    repeat (5) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/prefetch_pipe.md
Name: prefetch_pipe

Overview:
- Pipelined successor to the single-shot instruction prefetch.
- Keeps up to 2**LGDEPTH Wishbone (pipelined) reads outstanding and buffers returned words in an in-order FIFO of equal depth.
- Delivers instructions to the CPU one per cycle once primed.
- Sits between the ZipCPU decode stage and the instruction bus arbiter; same CPU-side handshake as the existing prefetch.

Parameters:
ADDRESS_WIDTH, 30, word-address width (AW); o_pc/i_pc are AW+2 bits byte addresses
DATA_WIDTH, 32, instruction/bus data width (DW)
LGDEPTH, 2, log2 of FIFO depth and maximum outstanding requests; DEPTH=2**LGDEPTH, LGDEPTH>=1
RESET_ADDRESS, 0, byte address fetched first after reset

Ports:
i_clk  in  1  clock, all logic on rising edge
i_reset_n  in  1  asynchronous active-low reset
i_new_pc  in  1  branch: restart fetch at i_pc
i_clear_cache  in  1  flush buffered/outstanding data; fetch halts until next i_new_pc
i_stalled_n  in  1  CPU accepts o_insn this cycle when o_valid=1
i_pc  in  AW+2  new fetch byte address; bits [1:0] ignored
o_insn  out  DW  instruction at FIFO head
o_pc  out  AW+2  byte address of o_insn, {word,2'b00}
o_valid  out  1  FIFO non-empty
o_illegal  out  1  head entry came from a bus error
o_wb_cyc, o_wb_stb  out  1 each  Wishbone cycle/strobe
o_wb_we  out  1  constant 0
o_wb_addr  out  AW  next word address to request
o_wb_data  out  DW  constant 0
i_wb_stall, i_wb_ack, i_wb_err  in  1 each  Wishbone responses
i_wb_data  in  DW  read data

Behaviour:
- Reset values (async assert, sync release):
  - cyc=stb=0, o_valid=0, o_illegal=0.
  - o_wb_addr=RESET_ADDRESS[AW+1:2]; o_pc=RESET_ADDRESS; counters 0.
  - o_insn undefined.
  - Fetching begins the cycle after release.
- State: pending (accepted, un-acked requests), count (FIFO entries), halted flag.
- Strobe acceptance:
  - A request is accepted when stb && !i_wb_stall; o_wb_addr+1 and pending+1 on that edge.
  - stb is asserted next cycle iff !halted, no new_pc/clear_cache this cycle, and count+pending+(accepted this cycle) < DEPTH after this cycle's pops/acks.
  - o_wb_addr only changes on acceptance or i_new_pc.
- Ack handling: on ack with cyc, push {0,i_wb_data}; pending-1.
- Cyc release: cyc drops when pending reaches 0 with stb low.
- Err handling: on err with cyc:
  - push {1,0}; drop cyc/stb; set halted; pending:=0.
  - Entries before the error are still delivered in order.
  - Halted stays set until i_new_pc.
- Pop: o_valid && i_stalled_n pops the head; o_pc advances by 4.
- Simultaneous push and pop: count unchanged.
- FIFO cannot overflow by construction; an ack arriving with count==DEPTH is a protocol violation (assertion).
- i_new_pc (priority over all but reset):
  - Flush FIFO (o_valid=0 next cycle); drop cyc/stb; pending:=0; clear halted.
  - o_wb_addr:=i_pc[AW+1:2]; o_pc:=i_pc with [1:0]=0.
  - Any ack/err/pop in the same cycle is discarded.
  - cyc/stb stay low exactly one cycle, rise on the second edge.
- Latency: new_pc at edge N → stb at N+2; with one-cycle ack, o_valid at N+4.
- i_clear_cache without i_new_pc: same flush/abort, then sets halted.
  - With i_new_pc in the same cycle, i_new_pc wins and fetch restarts.
- Acks/errs while cyc=0 are ignored.
- Address wrap: o_wb_addr wraps modulo 2**AW silently.

Decomposition:
- Shared package/header: bus width localparams (AW, DW), RESET_ADDRESS default, DEPTH derivation.
- One sub-module pf_fifo:
  - Synchronous FIFO of DEPTH × (DW+1), with push, pop, flush, count, empty outputs.
  - Async active-low reset on pointers only.
- Top block holds bus FSM, pending counter, halted flag and PC tracking.

Test Plan:
- Reset release, slave acks every cycle no stall, CPU always ready → o_pc 0,4,8,… consecutive, o_valid continuous after priming; pending never exceeds 4 (LGDEPTH=2).
- CPU stalled (i_stalled_n=0) 20 cycles → exactly 4 requests issued, stb low, FIFO full, no ack lost; release yields 4 in-order words, then fetch resumes.
- i_new_pc with i_pc=0x100 while 3 requests outstanding → cyc low one cycle, stale acks ignored, next o_valid shows o_pc=0x100 with data from word 0x40.
- Err on third response of burst at 0x0 → entries 0x0, 0x4 valid, then o_illegal=1 at o_pc=0x8; no further stb until i_new_pc; i_new_pc=0x20 clears o_illegal and restarts.
- i_clear_cache alone mid-burst → o_valid=0, cyc=0, stays idle 10 cycles; i_new_pc then restarts.
- Random i_wb_stall (50%) and async reset mid-burst → all outputs at reset values immediately, fetch restarts at RESET_ADDRESS after release.
